// File: rtl/sym_stats_gen.sv
// Multi-channel symbol-rate statistics: windowed means of |x|, x^2, err and err^2
// over 2^LOG2_LEN accepted symbols, published as registered snapshots with a valid strobe.
module sym_stats_gen #(
  parameter int WIDTH    = 18,
  parameter int LOG2_LEN = 22,
  parameter int CHANNELS = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      clk_en,
  input  logic                      mode,
  input  logic                      start,
  input  logic                      sync,
  input  logic                      hold,
  input  logic [CHANNELS*WIDTH-1:0] dec_var,
  input  logic [CHANNELS*WIDTH-1:0] err,
  output logic [CHANNELS*WIDTH-1:0] mean_abs,
  output logic [CHANNELS*WIDTH-1:0] mean_sq,
  output logic [CHANNELS*WIDTH-1:0] mean_err,
  output logic [CHANNELS*WIDTH-1:0] mean_sq_err,
  output logic                      valid,
  output logic                      busy
);

  localparam int ACC_W = WIDTH + LOG2_LEN;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] MAX_VAL = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {IDLE, ARMED, ACCUM} state_t;

  state_t              state_reg, state_next;
  logic                first_reg;
  logic [LOG2_LEN-1:0] count_reg;
  logic                valid_reg;
  logic                accept;
  logic                last_sample;

  // Count is zero outside ACCUM, so all-ones can only be seen on the window's final sample.
  assign accept      = clk_en && !hold && ((state_reg == ACCUM) || ((state_reg == ARMED) && sync));
  assign last_sample = accept && (&count_reg);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (start || (first_reg && !mode)) state_next = ARMED;
      ARMED:   if (accept) state_next = ACCUM;
      ACCUM:   if (last_sample) state_next = mode ? IDLE : ACCUM;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      first_reg <= 1'b1;
      count_reg <= '0;
      valid_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      first_reg <= 1'b0;
      valid_reg <= last_sample;
      if (accept) count_reg <= count_reg + LOG2_LEN'(1);
    end
  end

  assign valid = valid_reg;
  assign busy  = (state_reg != IDLE);

  for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
    logic signed [WIDTH-1:0]   x, e;
    logic        [WIDTH-1:0]   abs_x, sq_x, sq_e, sq_x_hi, sq_e_hi;
    logic signed [2*WIDTH-1:0] px, pe;
    logic        [ACC_W-1:0]   acc_abs_reg, acc_sq_reg, acc_se_reg;
    logic signed [ACC_W-1:0]   acc_err_reg;
    logic        [ACC_W-1:0]   sum_abs, sum_sq, sum_se;
    logic signed [ACC_W-1:0]   sum_err;
    logic        [WIDTH-1:0]   mean_abs_reg, mean_sq_reg, mean_se_reg;
    logic signed [WIDTH-1:0]   mean_err_reg;

    assign x = dec_var[gi*WIDTH +: WIDTH];
    assign e = err[gi*WIDTH +: WIDTH];

    assign abs_x = x[WIDTH-1] ? ((x == MIN_VAL) ? MAX_VAL : WIDTH'(-x)) : x;

    // Only (-1)*(-1) reaches the top kept bit, so that bit doubles as the saturation flag.
    assign px      = (2*WIDTH)'(x) * (2*WIDTH)'(x);
    assign pe      = (2*WIDTH)'(e) * (2*WIDTH)'(e);
    assign sq_x_hi = WIDTH'(px >> (WIDTH-1));
    assign sq_e_hi = WIDTH'(pe >> (WIDTH-1));
    assign sq_x    = sq_x_hi[WIDTH-1] ? MAX_VAL : sq_x_hi;
    assign sq_e    = sq_e_hi[WIDTH-1] ? MAX_VAL : sq_e_hi;

    assign sum_abs = acc_abs_reg + ACC_W'(abs_x);
    assign sum_sq  = acc_sq_reg  + ACC_W'(sq_x);
    assign sum_se  = acc_se_reg  + ACC_W'(sq_e);
    assign sum_err = acc_err_reg + ACC_W'(e);

    always_ff @(posedge clk) begin
      if (reset) begin
        acc_abs_reg  <= '0;
        acc_sq_reg   <= '0;
        acc_se_reg   <= '0;
        acc_err_reg  <= '0;
        mean_abs_reg <= '0;
        mean_sq_reg  <= '0;
        mean_se_reg  <= '0;
        mean_err_reg <= '0;
      end else if (accept) begin
        if (last_sample) begin
          acc_abs_reg  <= '0;
          acc_sq_reg   <= '0;
          acc_se_reg   <= '0;
          acc_err_reg  <= '0;
          mean_abs_reg <= WIDTH'(sum_abs >> LOG2_LEN);
          mean_sq_reg  <= WIDTH'(sum_sq >> LOG2_LEN);
          mean_se_reg  <= WIDTH'(sum_se >> LOG2_LEN);
          mean_err_reg <= WIDTH'(sum_err >>> LOG2_LEN);
        end else begin
          acc_abs_reg <= sum_abs;
          acc_sq_reg  <= sum_sq;
          acc_se_reg  <= sum_se;
          acc_err_reg <= sum_err;
        end
      end
    end

    assign mean_abs[gi*WIDTH +: WIDTH]    = mean_abs_reg;
    assign mean_sq[gi*WIDTH +: WIDTH]     = mean_sq_reg;
    assign mean_err[gi*WIDTH +: WIDTH]    = mean_err_reg;
    assign mean_sq_err[gi*WIDTH +: WIDTH] = mean_se_reg;
  end

endmodule

// File: tb/tb_sym_stats_gen.sv
// Randomised and directed bench for sym_stats_gen with a behavioural window-mean model
// checked every cycle, plus literal expectations for the documented corner cases.
module tb_sym_stats_gen;
  localparam int W = 18;
  localparam int L = 4;
  localparam int C = 2;
  localparam int N = 1 << L;

  logic clk = 1'b0;
  logic reset, clk_en, mode, start, sync, hold;
  logic [C*W-1:0] dec_var, err;
  logic [C*W-1:0] mean_abs, mean_sq, mean_err, mean_sq_err;
  logic valid, busy;

  sym_stats_gen #(.WIDTH(W), .LOG2_LEN(L), .CHANNELS(C)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .mode(mode), .start(start),
    .sync(sync), .hold(hold), .dec_var(dec_var), .err(err),
    .mean_abs(mean_abs), .mean_sq(mean_sq), .mean_err(mean_err),
    .mean_sq_err(mean_sq_err), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int vcount = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic longint sval(input logic [W-1:0] v);
    return longint'($signed(v));
  endfunction

  function automatic longint abs_sat(input longint v);
    if (v == -(longint'(1) << (W-1))) return (longint'(1) << (W-1)) - 1;
    return (v < 0) ? -v : v;
  endfunction

  function automatic longint sq_sat(input longint v);
    longint q;
    q = (v * v) / (longint'(1) << (W-1));
    if (q > (longint'(1) << (W-1)) - 1) q = (longint'(1) << (W-1)) - 1;
    return q;
  endfunction

  bit       model_on = 1'b0;
  int       m_state;          // 0 idle, 1 waiting for sync, 2 inside a window
  bit       m_first;
  int       m_cnt;
  longint   s_abs[C], s_sq[C], s_err[C], s_se[C];
  logic [W-1:0] e_abs[C], e_sq[C], e_err[C], e_se[C];
  bit       e_valid;

  always @(posedge clk) begin
    e_valid = 1'b0;
    if (reset) begin
      model_on = 1'b1;
      m_state = 0;
      m_first = 1'b1;
      m_cnt = 0;
      for (int c = 0; c < C; c++) begin
        s_abs[c] = 0; s_sq[c] = 0; s_err[c] = 0; s_se[c] = 0;
        e_abs[c] = '0; e_sq[c] = '0; e_err[c] = '0; e_se[c] = '0;
      end
    end else if (model_on) begin
      if (clk_en && !hold && (m_state == 2 || (m_state == 1 && sync))) begin
        for (int c = 0; c < C; c++) begin
          s_abs[c] += abs_sat(sval(dec_var[c*W +: W]));
          s_sq[c]  += sq_sat(sval(dec_var[c*W +: W]));
          s_err[c] += sval(err[c*W +: W]);
          s_se[c]  += sq_sat(sval(err[c*W +: W]));
        end
        m_cnt++;
        m_state = 2;
        if (m_cnt == N) begin
          for (int c = 0; c < C; c++) begin
            e_abs[c] = W'(s_abs[c] / N);
            e_sq[c]  = W'(s_sq[c] / N);
            e_se[c]  = W'(s_se[c] / N);
            e_err[c] = W'(s_err[c] >>> L);
            s_abs[c] = 0; s_sq[c] = 0; s_err[c] = 0; s_se[c] = 0;
          end
          m_cnt = 0;
          e_valid = 1'b1;
          m_state = mode ? 0 : 2;
        end
      end else if (m_state == 0 && (start || (m_first && !mode))) begin
        m_state = 1;
      end
      m_first = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (model_on) begin
      chk("valid", valid, e_valid);
      chk("busy", busy, (m_state != 0));
      for (int c = 0; c < C; c++) begin
        chk($sformatf("mean_abs[%0d]", c), mean_abs[c*W +: W], e_abs[c]);
        chk($sformatf("mean_sq[%0d]", c), mean_sq[c*W +: W], e_sq[c]);
        chk($sformatf("mean_err[%0d]", c), mean_err[c*W +: W], e_err[c]);
        chk($sformatf("mean_sq_err[%0d]", c), mean_sq_err[c*W +: W], e_se[c]);
      end
    end
    if (valid === 1'b1) vcount++;
  end

  // ---------------- stimulus ----------------
  // One symbol = 4 clocks with clk_en on the first.
  task automatic sym(input logic [W-1:0] d0, input logic [W-1:0] d1,
                     input logic [W-1:0] e0, input logic [W-1:0] e1,
                     input bit s, input bit h, input bit st);
    @(negedge clk);
    clk_en = 1'b1; dec_var = {d1, d0}; err = {e1, e0};
    sync = s; hold = h; start = st;
    @(negedge clk);
    clk_en = 1'b0; sync = 1'b0; start = 1'b0; hold = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset(input bit m);
    @(negedge clk);
    mode = m; reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_mean_abs", mean_abs, 0);
    chk("rst_mean_err", mean_err, 0);
    reset = 1'b0;
  endtask

  logic [W-1:0] P_HALF, N_HALF, P_Q, N_Q, NEG1, MINV;
  int base;

  initial begin
    P_HALF = 18'h10000; N_HALF = 18'h30000;
    P_Q = 18'h08000; N_Q = 18'h38000;
    NEG1 = 18'h3FFFF; MINV = 18'h20000;
    reset = 1'b1; clk_en = 1'b0; mode = 1'b0; start = 1'b0; sync = 1'b0; hold = 1'b0;
    dec_var = '0; err = '0;
    do_reset(1'b0);

    // Continuous: 0.5 on ch0, alternating +/-0.25 error on ch1
    sym(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++)
      sym(P_HALF, 0, 0, (i % 2) ? N_Q : P_Q, (i == 0), 1'b0, 1'b0);
    chk("w1_valid_count", vcount, 1);
    chk("w1_abs0", mean_abs[W-1:0], 18'h10000);
    chk("w1_sq0", mean_sq[W-1:0], 18'h08000);
    chk("w1_err1", mean_err[2*W-1:W], 18'h00000);
    chk("w1_sqerr1", mean_sq_err[2*W-1:W], 18'h02000);

    // Back-to-back window: most-negative value saturates, err of -1 LSB floors to -1
    for (int i = 0; i < N - 1; i++) sym(MINV, 0, 0, NEG1, 1'b0, 1'b0, 1'b0);
    chk("w2_not_early", vcount, 1);
    sym(MINV, 0, 0, NEG1, 1'b0, 1'b0, 1'b0);
    chk("w2_valid_count", vcount, 2);
    chk("w2_abs0", mean_abs[W-1:0], 18'h1FFFF);
    chk("w2_sq0", mean_sq[W-1:0], 18'h1FFFF);
    chk("w2_err1", mean_err[2*W-1:W], 18'h3FFFF);

    // Hold excludes five out-of-band symbols and stretches the window
    for (int i = 0; i < N + 5; i++) begin
      if (i >= 5 && i < 10) sym(NEG1, 0, 0, 0, 1'b0, 1'b1, 1'b0);
      else                  sym(P_HALF, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      if (i == N - 1) chk("hold_not_early", vcount, 2);
    end
    chk("hold_valid_count", vcount, 3);
    chk("hold_abs0", mean_abs[W-1:0], 18'h10000);

    // Random continuous traffic; sync must be ignored mid-stream
    for (int i = 0; i < 70; i++) begin
      logic [W-1:0] d0, d1, e0, e1;
      d0 = ($urandom_range(5) == 0) ? MINV : W'($urandom);
      d1 = W'($urandom);
      e0 = ($urandom_range(5) == 0) ? MINV : W'($urandom);
      e1 = W'($urandom_range(255)) - 18'd128;
      sym(d0, d1, e0, e1, ($urandom_range(4) == 0), ($urandom_range(7) == 0), 1'b0);
    end

    // Reset at symbol 10 of an aligned window
    do_reset(1'b0);
    for (int i = 0; i < N; i++) sym(P_HALF, N_HALF, P_Q, 0, (i == 0), 1'b0, 1'b0);
    base = vcount;
    chk("pre_rst_abs1", mean_abs[2*W-1:W], 18'h10000);
    for (int i = 0; i < 10; i++) sym(P_Q, P_Q, 0, 0, 1'b0, 1'b0, 1'b0);
    do_reset(1'b0);
    for (int i = 0; i < 3; i++) sym(P_Q, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) begin
      sym(P_Q, 0, 0, 0, (i == 0), 1'b0, 1'b0);
      if (i == N - 2) chk("post_rst_not_early", vcount, base);
    end
    chk("post_rst_valid", vcount, base + 1);
    chk("post_rst_abs0", mean_abs[W-1:0], 18'h08000);

    // Single-shot capture
    do_reset(1'b1);
    sym(P_HALF, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("ss_idle_busy", busy, 0);
    base = vcount;
    sym(NEG1, 0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("ss_armed_busy", busy, 1);
    sym(NEG1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    sym(NEG1, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < N; i++) sym(N_HALF, 0, P_Q, 0, (i == 0), 1'b0, (i == 5));
    chk("ss_one_valid", vcount, base + 1);
    chk("ss_abs0", mean_abs[W-1:0], 18'h10000);
    chk("ss_err0", mean_err[W-1:0], 18'h08000);
    chk("ss_done_busy", busy, 0);
    for (int i = 0; i < 3; i++) sym(P_HALF, 0, 0, 0, 1'b1, 1'b0, 1'b0);
    chk("ss_no_rearm", vcount, base + 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/sym_stats_gen.md
# sym_stats_gen

Parametrised, multi-channel symbol-rate statistics engine for the receive decision path. Over an aligned window of 2^LOG2_LEN enabled symbols it accumulates, per channel, mean |decision variable|, mean power, mean (DC) error and mean squared error. Results are published as registered snapshots with a one-clock valid strobe. It sits after the downsampler/slicer and replaces the separate reference-level, squared-error and DC-error accumulators with one block that supports I/Q (or more) channels, a configurable window and continuous or single-shot capture.

## Interface
- WIDTH, 18, sample width, signed 1s(WIDTH-1) format
- LOG2_LEN, 22, log2 of window length in enabled symbols (2^22 matches LFSR period)
- CHANNELS, 2, independent channels (0 = in-phase, 1 = quadrature)

- clk  in  1  system clock (sys_clk); only clock
- reset  in  1  synchronous, active-high
- clk_en  in  1  symbol enable (sym_clk_en); all sampling qualified by it
- mode  in  1  0 = continuous, 1 = single-shot
- start  in  1  single-shot arm request
- sync  in  1  window alignment marker (e.g. LFSR periodic cycle pulse)
- hold  in  1  1 = ignore current enabled sample (not counted, not accumulated)
- dec_var  in  CHANNELS*WIDTH  decision variables; channel c at [c*WIDTH +: WIDTH]
- err  in  CHANNELS*WIDTH  slicer error (dec_var − mapped symbol), same packing
- mean_abs  out  CHANNELS*WIDTH  mean |dec_var|, unsigned magnitude in signed container
- mean_sq  out  CHANNELS*WIDTH  mean dec_var²
- mean_err  out  CHANNELS*WIDTH  mean err, signed
- mean_sq_err  out  CHANNELS*WIDTH  mean err²
- valid  out  1  one-clock strobe: new snapshot on all mean_* outputs
- busy  out  1  1 while in ARMED or ACCUM

## Operation
- Accepted sample: clk_en=1 and hold=0 while in ACCUM, or while in ARMED with sync=1.
- FSM states: IDLE, ARMED, ACCUM.
  - IDLE: start=1 → ARMED. start ignored in every other state.
  - ARMED: accepted sample (sync=1) → ACCUM; that sample is sample 0 of the window.
  - ACCUM: count accepted samples. The sample that makes count reach 2^LOG2_LEN ends the window → snapshot taken, accumulators and count cleared. Then go to ACCUM (mode=0, no realignment) or IDLE (mode=1).
- After reset: mode=0 → ARMED; mode=1 → IDLE. mode is sampled only on reset exit and at window end.
- sync in ACCUM is ignored; windows stay contiguous.
- Per-channel arithmetic:
  - |x|: −2^(WIDTH−1) saturates to 2^(WIDTH−1)−1.
  - x²: full 2WIDTH-bit signed product; take bits [2WIDTH−2:WIDTH−1]. The −1×−1 case saturates to 2^(WIDTH−1)−1. Applies to dec_var² and err².
  - Accumulators: WIDTH+LOG2_LEN bits, signed for err and unsigned for the others; they cannot overflow.
  - Snapshot = (accumulator + final sample term) >> LOG2_LEN; arithmetic shift for mean_err (floor toward −∞), truncation elsewhere.
- Outputs hold the last snapshot until the next window end.
- busy=1 in ARMED and ACCUM, else 0.

## Timing
- Reset values: all mean_* = 0, valid = 0, busy = 0, accumulators and count = 0.
- Reset mid-window discards partial sums; the previous snapshot is also cleared to 0.
- Snapshot registered on the clk edge where the final sample is accepted. mean_* and valid are visible the following cycle; valid is high exactly one clk.
- Continuous mode: first sample of the next window may be accepted on the very next clk_en; no dead symbol.
- hold=1 on the final sample's clk_en delays window end to the next accepted sample.
- Per-channel datapath is fully parallel; all channels snapshot on the same edge.
- Critical path: WIDTH×WIDTH multiply plus accumulator add. Single-cycle at sys_clk is required; registering the products is allowed only if valid still rises once per window with unchanged snapshot contents.

## Test plan
Bench uses LOG2_LEN=4 (16-symbol window), WIDTH=18, clk_en every 4th clk.
- Continuous mode, sync at first symbol, dec_var ch0 = 18'sh10000 (0.5) for 16 symbols → valid after 16th accepted symbol; mean_abs=0x10000, mean_sq=0x08000; next valid exactly 16 symbols later.
- err ch1 alternating 18'sh08000 / −18'sh08000 → mean_err=0, mean_sq_err=0x02000. err constant −1 LSB → mean_err=0x3FFFF.
- dec_var = −2^17 (0x20000) all window → mean_abs=0x1FFFF, mean_sq=0x1FFFF (saturation).
- hold=1 for 5 symbols mid-window with dec_var=0x3FFFF on those symbols only and 0x10000 otherwise → held samples excluded; valid appears 5 symbols late; mean_abs=0x10000.
- Single-shot: mode=1, start pulse, sync arrives 3 symbols later → busy rises after start; accumulation starts at the sync symbol; one valid; returns to IDLE with busy=0. A second start during ACCUM is ignored.
- Reset asserted at symbol 10 of a window → next cycle all outputs 0, busy=0; after release the first valid comes 16 accepted symbols after the next sync-aligned sample.
